// File: rtl/hex_display_ctrl.sv
// Arbitrates two display clients round-robin, scans the granted value through the shared
// external 7-segment decoder into shadow registers, then commits all six digits at once.
//
// state  | meaning
// IDLE   | wait for req_a/req_b; the first IDLE cycle after a commit never grants
// SCAN   | one nibble per cycle: dec_out of the current nibble lands in shadow[idx]
// COMMIT | done pulses; shadow copied to the display on the edge leaving this state
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_a,
    input  logic [23:0] val_a,
    input  logic        req_b,
    input  logic [23:0] val_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        busy,
    output logic        done,
    output logic [3:0]  dec_in,
    input  logic [6:0]  dec_out,
    input  logic [5:0]  blank_mask,
    input  logic        blink_en,
    output logic [41:0] hex_out
);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);
    localparam int         CW       = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

    state_t      state;
    logic [23:0] frame;
    logic [2:0]  idx;
    logic [4:0]  next_base;
    logic        last_b;
    logic        settle;
    logic [6:0]  shadow [NUM_DIGITS];
    logic [6:0]  disp   [NUM_DIGITS];
    logic [CW-1:0] blink_cnt;
    logic        phase_off;

    assign next_base = {idx + 3'd1, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dec_in <= 4'd0;
            frame  <= 24'd0;
            idx    <= 3'd0;
            last_b <= 1'b1;
            settle <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= 7'h7F;
                disp[i]   <= 7'h7F;
            end
        end else begin
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (settle) begin
                        settle <= 1'b0;
                    end else if (req_a && (!req_b || last_b)) begin
                        gnt_a  <= 1'b1;
                        frame  <= val_a;
                        dec_in <= val_a[3:0];
                        idx    <= 3'd0;
                        last_b <= 1'b0;
                        busy   <= 1'b1;
                        state  <= SCAN;
                    end else if (req_b) begin
                        gnt_b  <= 1'b1;
                        frame  <= val_b;
                        dec_in <= val_b[3:0];
                        idx    <= 3'd0;
                        last_b <= 1'b1;
                        busy   <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    shadow[idx] <= dec_out;
                    if (idx == LAST_IDX) begin
                        done  <= 1'b1;
                        state <= COMMIT;
                    end else begin
                        idx    <= idx + 3'd1;
                        dec_in <= frame[next_base +: 4];
                    end
                end
                COMMIT: begin
                    // Whole-frame copy keeps the visible display free of mixed frames.
                    for (int i = 0; i < NUM_DIGITS; i++) disp[i] <= shadow[i];
                    busy   <= 1'b0;
                    settle <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase_off <= 1'b0;
        end else if (!blink_en) begin
            blink_cnt <= '0;
            phase_off <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase_off <= ~phase_off;
        end else begin
            blink_cnt <= blink_cnt + CW'(1);
        end
    end

    // Blanking only gates the output; stored digits are untouched.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_hex
        assign hex_out[7*g +: 7] = (blank_mask[g] || (blink_en && phase_off)) ? 7'h7F : disp[g];
    end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Drives all six DE1-SoC HEX displays through a single shared hex-to-7-segment decoder, which is instantiated outside this block.
- Two clients (A, B) request display updates. The block arbitrates between them round-robin.
- It scans the granted 24-bit value nibble by nibble through the decoder, collects the codes in shadow registers and commits all six digits at once.
- It also applies per-digit blanking and a global blink.

Parameters:
- NUM_DIGITS, 6, number of HEX digits scanned. Fixed at 6 for DE1-SoC; port widths assume 6.
- BLINK_DIV, 25000000, clk cycles per blink half-period (0.5 s at 50 MHz). Must be ≥2.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- req_a  in  1  client A update request, level; held until gnt_a
- val_a  in  24  client A value; nibble i goes to HEX i
- req_b  in  1  client B update request, level; held until gnt_b
- val_b  in  24  client B value
- gnt_a  out  1  one-cycle pulse; val_a captured on this edge
- gnt_b  out  1  one-cycle pulse; val_b captured on this edge
- busy  out  1  update in progress
- done  out  1  one-cycle pulse in COMMIT state
- dec_in  out  4  nibble to shared decoder (registered)
- dec_out  in  7  decoder result, active-low segments, combinational from dec_in
- blank_mask  in  6  bit i=1 forces HEX i dark
- blink_en  in  1  enable global blink
- hex_out  out  42  HEX i = hex_out[7i+6:7i], active-low

Behaviour:
- Reset (async assert, sync release) sets:
  - state=IDLE, gnt_a=gnt_b=busy=done=0, dec_in=0.
  - Display and shadow registers = 7'h7F (all dark).
  - last_grant=B, so A wins the first tie.
  - blink counter=0, phase=ON.
- Reset mid-scan aborts the update. The display goes dark; no done pulse is issued.
- FSM IDLE, SCAN, COMMIT:
  - IDLE, no request: stay in IDLE.
  - IDLE, only one req_x high: pulse gnt_x.
    - frame <= val_x, dec_in <= val_x[3:0], idx <= 0.
    - Go to SCAN; busy=1 from the next cycle.
  - IDLE, both requests high: grant the client that is not last_grant, then update last_grant.
  - SCAN, each cycle:
    - shadow[idx] <= dec_out.
    - If idx==NUM_DIGITS-1, go to COMMIT.
    - Else idx++ and dec_in <= frame[4(idx+1)+3 : 4(idx+1)].
  - COMMIT: done=1, busy=1. The display register <= all shadow registers, written on the edge that leaves COMMIT. Return to IDLE; busy=0.
- Timing:
  - Grant edge to display update = NUM_DIGITS+2 edges (8).
  - A new grant requires at least one IDLE cycle, so minimum period between grants = NUM_DIGITS+3 cycles (9).
- Requests while busy are not granted and not lost; they are served in the next IDLE cycle.
- A req_x dropped before its grant is forgotten.
- The visible display never shows a partially updated frame.
- Blink:
  - If blink_en=0: counter held at 0, phase=ON.
  - Otherwise the counter counts 0..BLINK_DIV-1. At wrap, phase toggles and the counter returns to 0.
- Output, combinational from registers:
  - HEX i = 7'h7F if blank_mask[i], or if (blink_en and phase==OFF).
  - Otherwise HEX i = display register i.
  - Blanking does not alter stored digits; unmasking shows them immediately.
- A done pulse and a new grant cannot occur in the same cycle.

Test Plan:
- Reset: rst_n low mid-run → hex_out=42'h3FF_FFFF_FFFF, busy=0, dec_in=0, no gnt pulses.
- Single update: req_a with val_a=24'h000810, decoder model attached → gnt_a at edge T; dec_in sequence 0,1,8,0,0,0 on cycles T+1..T+6; done at T+7; hex_out at T+8 = HEX0 1000000, HEX1 1111001, HEX2 0000000, HEX3-5 1000000.
- Contention: req_a and req_b held high together for 40 cycles → grants alternate A,B,A,B, each 9 cycles apart; 4 done pulses; final hex_out equals val_b's decode.
- Request during busy: req_b asserted 3 cycles after gnt_a → gnt_b not issued until the IDLE cycle after done; hex_out never shows a mix of A and B digits.
- Blank/blink with BLINK_DIV=4:
  - blank_mask=6'b000001 → HEX0=7F, others unchanged.
  - blink_en=1 → whole display dark/lit alternating every 4 cycles.
  - blink_en=0 → lit the cycle after.
- Reset mid-scan: rst_n pulsed at T+3 after a grant → no done pulse, display dark; a new req_a afterwards completes normally in 8 edges.
